// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sample widths and saturation helper for the FIR chain
package fir_pkg;
  localparam int FIR_IN_W  = 16;
  localparam int FIR_ACC_W = 32;
  localparam int OUT_W     = 16;

  localparam logic signed [FIR_ACC_W:0] SAT_MAX = (FIR_ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [FIR_ACC_W:0] SAT_MIN = (FIR_ACC_W+1)'(-(2**(OUT_W-1)));

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] value;
  } sat_sample_t;

  function automatic sat_sample_t saturate(input logic signed [FIR_ACC_W:0] v);
    sat_sample_t r;
    r.sat   = 1'b0;
    r.value = v[OUT_W-1:0];
    if (v > SAT_MAX) begin
      r.sat   = 1'b1;
      r.value = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r.sat   = 1'b1;
      r.value = {1'b1, {(OUT_W-1){1'b0}}};
    end
    return r;
  endfunction
endpackage

// File: rtl/fir_decim_requant_if.sv
// rtl/fir_decim_requant_if.sv - sample stream in, requantized stream out
interface fir_decim_requant_if;
  import fir_pkg::*;

  logic signed [FIR_ACC_W-1:0] data_in;
  logic                        in_valid;
  logic signed [OUT_W-1:0]     data_out;
  logic                        out_valid;
  logic                        out_ready;

  modport master (output data_in, in_valid, out_ready, input data_out, out_valid);
  modport slave  (input data_in, in_valid, out_ready, output data_out, out_valid);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; push while full is only taken alongside a pop
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + (AW+1)'(1);
      else if (do_pop && !do_push) level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fir_decim_requant.sv
// rtl/fir_decim_requant.sv - decimate, round, saturate to 16 bits and buffer FIR output
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter int DECIM = 2,
  parameter int SHIFT = 15,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fir_decim_requant_if.slave     bus,
  output logic                   sat_pulse,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [FIR_ACC_W:0] ROUND = (FIR_ACC_W+1)'(2**(SHIFT-1));

  logic [CW-1:0]             phase;
  logic                      accept;
  logic                      s1_valid;
  logic signed [FIR_ACC_W:0] s1_value;
  logic                      s2_valid;
  sat_sample_t               s2;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [OUT_W-1:0]          fifo_dout;
  logic                      pop;

  assign accept = bus.in_valid && (phase == '0);

  // Extra sign bit keeps the rounding add from wrapping near full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      s1_valid <= 1'b0;
      s1_value <= '0;
      s2_valid <= 1'b0;
      s2       <= '0;
      overflow <= 1'b0;
    end else begin
      if (bus.in_valid) phase <= (phase == CW'(DECIM-1)) ? '0 : phase + CW'(1);
      s1_valid <= accept;
      if (accept) s1_value <= ($signed({bus.data_in[FIR_ACC_W-1], bus.data_in}) + ROUND) >>> SHIFT;
      s2_valid <= s1_valid;
      if (s1_valid) s2 <= saturate(s1_value);
      if (s2_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign sat_pulse     = s2_valid && s2.sat;
  assign bus.out_valid = !fifo_empty;
  assign bus.data_out  = fifo_empty ? '0 : fifo_dout;
  assign pop           = bus.out_valid && bus.out_ready;

  sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s2_valid),
    .din   (s2.value),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );
endmodule

// File: tb/tb_fir_decim_requant.sv
// tb/tb_fir_decim_requant.sv - bench for fir_decim_requant at DECIM=2 and DECIM=1
module tb_fir_decim_requant;
  localparam int DEPTH = 8;
  localparam int SH    = 15;
  localparam int NE    = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;

  logic       sat0, ovf0, sat1, ovf1;
  logic [3:0] lvl0, lvl1;

  fir_decim_requant_if bus0 ();
  fir_decim_requant_if bus1 ();

  assign bus0.data_in = din;
  assign bus0.in_valid = iv;
  assign bus0.out_ready = ordy;
  assign bus1.data_in = din;
  assign bus1.in_valid = iv;
  assign bus1.out_ready = ordy;

  fir_decim_requant #(.DECIM(2), .SHIFT(SH), .DEPTH(DEPTH)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .sat_pulse(sat0), .overflow(ovf0), .level(lvl0));
  fir_decim_requant #(.DECIM(1), .SHIFT(SH), .DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .sat_pulse(sat1), .overflow(ovf1), .level(lvl1));

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference: each accepted sample becomes a FIFO write exactly two edges later.
  bit acc_v   [2][NE];
  int acc_val [2][NE];
  bit acc_sat [2][NE];
  int mq0[$];
  int mq1[$];
  bit movf [2];
  int nvalid [2];
  int e = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic int qhead(input int k);
    if (qsize(k) == 0) return 0;
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic void qpop(input int k);
    if (k == 0) void'(mq0.pop_front());
    else void'(mq1.pop_front());
  endfunction

  function automatic void qpush(input int k, input int v);
    if (k == 0) mq0.push_back(v);
    else mq1.push_back(v);
  endfunction

  function automatic void quant(input logic [31:0] x, output int v, output bit s);
    longint t;
    t = (longint'($signed(x)) + (longint'(1) << (SH - 1))) >>> SH;
    s = 1'b0;
    if (t > 32767) begin t = 32767; s = 1'b1; end
    if (t < -32768) begin t = -32768; s = 1'b1; end
    v = int'(t);
  endfunction

  function automatic void model_edge(input int k, input int decim);
    int v;
    bit s;
    acc_v[k][e] = 1'b0;
    if (rst) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      movf[k] = 1'b0;
      nvalid[k] = 0;
      acc_v[k][e-1] = 1'b0;
      return;
    end
    if (ordy && qsize(k) > 0) qpop(k);
    if (e >= 2 && acc_v[k][e-2]) begin
      if (qsize(k) < DEPTH) qpush(k, acc_val[k][e-2]);
      else movf[k] = 1'b1;
    end
    if (iv) begin
      if (nvalid[k] % decim == 0) begin
        quant(din, v, s);
        acc_v[k][e] = 1'b1;
        acc_val[k][e] = v;
        acc_sat[k][e] = s;
      end
      nvalid[k]++;
    end
  endfunction

  task automatic chk_dut(input int k, input int dout, input logic ov, input logic sp,
                         input logic of, input int lv);
    string p;
    p = (k == 0) ? "m0" : "m1";
    chk({p, "_out_valid"}, int'(ov), int'(qsize(k) > 0));
    chk({p, "_data_out"}, dout, qhead(k));
    chk({p, "_level"}, lv, qsize(k));
    chk({p, "_overflow"}, int'(of), int'(movf[k]));
    chk({p, "_sat_pulse"}, int'(sp), int'(acc_v[k][e-1] && acc_sat[k][e-1]));
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    if (e >= NE) begin
      $display("FAIL edge_budget: got %0d expected below %0d", e, NE);
      $fatal(1, "edge budget exhausted");
    end
    model_edge(0, 2);
    model_edge(1, 1);
    #1;
    chk_dut(0, int'($signed(bus0.data_out)), bus0.out_valid, sat0, ovf0, int'(lvl0));
    chk_dut(1, int'($signed(bus1.data_out)), bus1.out_valid, sat1, ovf1, int'(lvl1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iv = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] x;
    int          y;
    bit          s;
  } vec_t;

  vec_t vecs[6];
  bit   gap_pat[9];

  initial begin
    int thr;
    int kv;
    vecs[0] = '{32'd16384, 1, 1'b0};
    vecs[1] = '{32'd49152, 2, 1'b0};
    vecs[2] = '{-32'sd16384, 0, 1'b0};
    vecs[3] = '{-32'sd16385, -1, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32767, 1'b1};
    vecs[5] = '{32'h8000_0000, -32768, 1'b1};
    gap_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset held with random inputs, then idle
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = $urandom; iv = 1'($urandom); ordy = 1'($urandom);
      step();
      chk("rst_level", int'(lvl0), 0);
      chk("rst_out_valid", int'(bus0.out_valid), 0);
      chk("rst_data_out", int'(bus0.data_out), 0);
      chk("rst_sat_pulse", int'(sat0), 0);
      chk("rst_overflow", int'(ovf0), 0);
    end
    rst = 1'b0; iv = 1'b0; ordy = 1'b1;
    step();
    chk("idle_out_valid", int'(bus0.out_valid), 0);
    chk("idle_level", int'(lvl0), 0);

    // rounding and saturation at DECIM=1
    for (int i = 0; i < 6; i++) begin
      din = vecs[i].x; iv = 1'b1;
      step();
      iv = 1'b0;
      step();
      chk("tbl_sat_pulse", int'(sat1), int'(vecs[i].s));
      chk("tbl_early_valid", int'(bus1.out_valid), 0);
      step();
      chk("tbl_out_valid", int'(bus1.out_valid), 1);
      chk("tbl_data_out", int'($signed(bus1.data_out)), vecs[i].y);
    end

    // decimation with continuous in_valid
    do_reset();
    ordy = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      din = 32'(k << 15); iv = 1'b1;
      step();
    end
    iv = 1'b0;
    step(); step();
    chk("dec_level", int'(lvl0), 4);
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("dec_data_out", int'($signed(bus0.data_out)), 2 * i + 1);
      step();
    end
    chk("dec_drained", int'(bus0.out_valid), 0);

    // gaps in in_valid do not move the decimation phase
    do_reset();
    ordy = 1'b0;
    kv = 0;
    for (int i = 0; i < 9; i++) begin
      iv = gap_pat[i];
      if (iv) begin kv++; din = 32'(kv << 15); end
      step();
    end
    iv = 1'b0;
    step(); step();
    chk("gap_level", int'(lvl0), 3);
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("gap_data_out", int'($signed(bus0.data_out)), 2 * i + 1);
      step();
    end

    // backpressure: 20 accepted into an 8-deep FIFO
    do_reset();
    ordy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      din = 32'(k << 15); iv = 1'b1;
      step();
    end
    iv = 1'b0;
    step(); step();
    chk("bp_level", int'(lvl0), 8);
    chk("bp_overflow", int'(ovf0), 1);
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_data_out", int'($signed(bus0.data_out)), 2 * i + 1);
      step();
    end
    chk("bp_drained", int'(bus0.out_valid), 0);

    // mid-operation reset with level 5 and a sample in stage 1
    ordy = 1'b0;
    for (int k = 101; k <= 111; k++) begin
      din = 32'(k << 15); iv = 1'b1;
      step();
    end
    chk("mid_level_pre", int'(lvl0), 5);
    chk("mid_overflow_pre", int'(ovf0), 1);
    do_reset();
    chk("mid_level", int'(lvl0), 0);
    chk("mid_overflow", int'(ovf0), 0);
    ordy = 1'b1;
    step(); step();
    chk("mid_no_stale", int'(bus0.out_valid), 0);
    din = 32'(200 << 15); iv = 1'b1;
    step();
    iv = 1'b0;
    step(); step();
    chk("mid_out_valid", int'(bus0.out_valid), 1);
    chk("mid_data_out", int'($signed(bus0.data_out)), 200);

    // random traffic against the reference
    thr = 80;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) thr = int'($urandom_range(10, 100));
      rst = ($urandom_range(0, 199) == 0);
      iv = ($urandom_range(0, 2) != 0);
      ordy = (int'($urandom_range(0, 99)) < thr);
      if ($urandom_range(0, 3) == 0) din = $urandom;
      else din = 32'((int'($urandom_range(0, 80000)) - 40000) * 32768 + int'($urandom_range(0, 32767)));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
